lsu: RTL and testbench
======================

# lsu

Load/store unit that sits between the core's memory stage and the single-port synchronous data RAM wrapper. It accepts byte-addressed RV32I loads and stores (byte, half, word; signed or unsigned loads) over a valid/ready handshake and converts them into word-addressed RAM reads and writes. The RAM has no byte enables, so sub-word stores use a read-modify-write sequence. It also performs load extraction and sign/zero extension, and flags misaligned or out-of-range accesses.

## Interface
- WIDTH, 32, data and byte-address width
- ADDR_W, 12, RAM word-address width; capacity 2^ADDR_W words
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  0 load, 1 store
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads only: 1 zero-extend, 0 sign-extend
- req_addr  in  WIDTH  byte address
- req_wdata  in  WIDTH  store data; low byte/half used for sub-word stores
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid; misaligned, out-of-range or reserved size
- mem_addr  out  ADDR_W  RAM word address
- mem_wren  out  1  RAM write enable
- mem_wr_data  out  WIDTH  RAM write data
- mem_rd_data  in  WIDTH  RAM read data, valid one cycle after address is sampled

## Operation
- States: IDLE, READ, WAIT, WRITE, RESP. All outputs are registered or decoded from state.
- IDLE:
  - req_ready=1.
  - On req_valid, capture the whole request.
  - Error check: half with addr[0]≠0; word with addr[1:0]≠0; size 11; or addr[WIDTH-1:ADDR_W+2]≠0. Any error → RESP with err=1. No RAM access is issued.
  - Word store → WRITE.
  - Load or sub-word store → READ.
- READ: mem_addr=addr[ADDR_W+1:2], mem_wren=0 → WAIT.
- WAIT: mem_rd_data is valid this cycle.
  - Load: select the lane by addr[1:0] (little-endian; half uses addr[1]), extend per req_unsigned/size, register into resp_rdata → RESP.
  - Sub-word store: merge the store byte/half into the read word at that lane, register as the merge word → WRITE.
- WRITE: mem_wren=1 for exactly this cycle, mem_addr=word address. mem_wr_data=req_wdata (word store) or the merge word → RESP.
- RESP: resp_valid=1 for one cycle, then → IDLE.
  - resp_err is set as determined in IDLE.
  - resp_rdata=0 for stores and errors.
- Outside IDLE, req_ready=0. No request is accepted until the unit has returned to IDLE.
- Outside WRITE, mem_wren=0.
- mem_addr holds its last value outside READ/WRITE.

## Timing
- Handshake cycle = cycle 0, in IDLE. resp_valid is asserted in:
  - LW/LH/LB/LHU/LBU: cycle 3.
  - SW: cycle 2.
  - SB/SH: cycle 4.
  - Error: cycle 1.
- Back-to-back: the next handshake can occur in the cycle after RESP. Throughput is one request per 3/4/5 cycles.
- Reset (rst=0), asynchronous:
  - state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wren=0, mem_addr=0, mem_wr_data=0.
- Reset mid-operation: the in-flight request is dropped with no response. If asserted during WRITE, mem_wren falls immediately.
- resp_rdata and resp_err hold their values after RESP until the next RESP.
- Arithmetic: sign extension replicates bit 7 (byte) or bit 15 (half) into the upper bits.

## Test plan
- LW addr 0x10, RAM word 4 = 0x8899AABB → resp_valid at cycle 3, rdata 0x8899AABB, err 0. RAM sees mem_addr=4 in READ.
- LB addr 0x13, same word → rdata 0xFFFFFF88. LBU → 0x00000088. LH addr 0x12 → 0xFFFF8899. LHU addr 0x10 → 0x0000AABB.
- SB addr 0x11, wdata 0x000000CC, word 4 = 0x8899AABB → single mem_wren pulse at cycle 3 with data 0x8899CCBB, resp at cycle 4. A following LW of 0x10 returns 0x8899CCBB.
- SW addr 0x20, wdata 0xDEADBEEF → mem_wren at cycle 1 with mem_addr=8, no read issued, resp at cycle 2.
- LW addr 0x12, SH addr 0x01, size 11, and addr 0x4000 (ADDR_W=12) → resp at cycle 1, err=1, rdata=0, mem_wren never asserted.
- Deassert rst during the WRITE of an SB → mem_wren drops the same cycle, no resp_valid, req_ready=1. The next request completes normally.

Source files
------------

// File: rtl/lsu.sv
// RV32I load/store unit in front of a word-addressed RAM without byte enables.
// Sub-word stores are performed as read-modify-write.
module lsu #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [WIDTH-1:0]  req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              resp_valid,
  output logic [WIDTH-1:0]  resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [WIDTH-1:0]  mem_wr_data,
  input  logic [WIDTH-1:0]  mem_rd_data
);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, WRITE, RESP
  } state_t;

  state_t state, state_nx;

  logic [1:0]       lane;
  logic [1:0]       size_q;
  logic             uns_q;
  logic             we_q;
  logic [15:0]      wdata_q;
  logic             bad;
  logic             word_st;
  logic [4:0]       sh;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] merged;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_wren   = (state == WRITE);
  assign word_st    = req_we && (req_size == 2'b10);

  always_comb begin
    bad = 1'b0;
    unique case (req_size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = req_addr[0];
      2'b10:   bad = |req_addr[1:0];
      default: bad = 1'b1;
    endcase
    if ((req_addr >> (ADDR_W + 2)) != '0)
      bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad)          state_nx = RESP;
          else if (word_st) state_nx = WRITE;
          else              state_nx = READ;
        end
      end
      READ:    state_nx = WAIT;
      WAIT:    state_nx = we_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane select for loads and lane merge for sub-word stores
  always_comb begin
    sh       = {lane, 3'b000};
    shifted  = mem_rd_data >> sh;
    load_val = shifted;
    merged   = mem_rd_data;
    case (size_q)
      2'b00: begin
        load_val = {{(WIDTH-8){~uns_q & shifted[7]}},
                    shifted[7:0]};
        merged   = (mem_rd_data & ~(WIDTH'(8'hFF) << sh))
                 | (WIDTH'(wdata_q[7:0]) << sh);
      end
      2'b01: begin
        load_val = {{(WIDTH-16){~uns_q & shifted[15]}},
                    shifted[15:0]};
        merged   = (mem_rd_data & ~(WIDTH'(16'hFFFF) << sh))
                 | (WIDTH'(wdata_q) << sh);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane        <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lane    <= req_addr[1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            we_q    <= req_we;
            wdata_q <= req_wdata[15:0];
            if (bad) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_addr <= req_addr[ADDR_W+1:2];
              if (word_st)
                mem_wr_data <= req_wdata;
            end
          end
        end
        WAIT: begin
          if (we_q) begin
            mem_wr_data <= merged;
          end else begin
            resp_rdata <= load_val;
            resp_err   <= 1'b0;
          end
        end
        WRITE: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: RAM model, directed vector table, reset-in-WRITE
// sequence and randomized traffic against a byte-level reference.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [11:0] mem_addr;
  logic        mem_wren;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  int checks = 0;
  int errors = 0;

  lsu #(.WIDTH(32), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wren(mem_wren),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // synchronous single-port RAM with a preload path
  logic [31:0] ram [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en)         ram[pl_addr] <= pl_data;
    else if (mem_wren) ram[mem_addr] <= mem_wr_data;
    mem_rd_data <= ram[mem_addr];
  end

  logic [31:0] ref_mem [64];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: byte-lane arithmetic on a word array
  task automatic model(input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err,
                       output int cyc, output int wcyc);
    int nb, off, w;
    logic [31:0] word, val;
    nb  = 1 << size;
    off = int'(addr % 4);
    err = (size == 2'd3) || (addr % nb != 0) || (addr >= 32'h4000);
    rd = '0; cyc = 1; wcyc = 0;
    if (!err) begin
      w = int'(addr / 4);
      word = ref_mem[w];
      if (!we) begin
        cyc = 3;
        val = word >> (8 * off);
        if (nb == 1) begin
          val = val & 32'hFF;
          if (!uns && val[7]) val = val | 32'hFFFFFF00;
        end else if (nb == 2) begin
          val = val & 32'hFFFF;
          if (!uns && val[15]) val = val | 32'hFFFF0000;
        end
        rd = val;
      end else begin
        for (int k = 0; k < nb; k++)
          word[8*(off+k) +: 8] = wdata[8*k +: 8];
        ref_mem[w] = word;
        cyc  = (nb == 4) ? 2 : 4;
        wcyc = cyc - 1;
      end
    end
  endtask

  task automatic run(input logic we, input logic [1:0] size,
                     input logic uns, input logic [31:0] addr,
                     input logic [31:0] wdata,
                     output logic [31:0] rd, output logic err,
                     output int cyc, output int wcnt, output int wcyc,
                     output logic [31:0] wdat,
                     output logic [11:0] wadr);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    wcnt = 0; wcyc = 0; wdat = '0; wadr = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 12) begin
      if (mem_wren) begin
        wcnt++; wcyc = cyc; wdat = mem_wr_data; wadr = mem_addr;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (mem_wren) wcnt++;
    if (!resp_valid) cyc = -1;
    rd = resp_rdata;
    err = resp_err;
    @(posedge clk); #1;
    chk("resp_pulse", {31'b0, resp_valid}, 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    int          cyc;
    int          wcyc;
    logic [31:0] wdat;
  } vec_t;

  vec_t tbl [20] = '{
    '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 3, 0, 32'h0},
    '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 3, 0, 32'h0},
    '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h00000088, 1'b0, 3, 0, 32'h0},
    '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 3, 0, 32'h0},
    '{1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 3, 0, 32'h0},
    '{1'b1, 2'd0, 1'b0, 32'h11, 32'hCC, 32'h0, 1'b0, 4, 3, 32'h8899CCBB},
    '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8899CCBB, 1'b0, 3, 0, 32'h0},
    '{1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1,
      32'hDEADBEEF},
    '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 32'h0},
    '{1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0},
    '{1'b1, 2'd1, 1'b0, 32'h01, 32'h5555, 32'h0, 1'b1, 1, 0, 32'h0},
    '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0},
    '{1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0},
    '{1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF7E55, 32'h0, 1'b0, 4, 3,
      32'h7E55CCBB},
    '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h00007E55, 1'b0, 3, 0, 32'h0},
    '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 3, 0, 32'h0},
    '{1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 32'h00000055, 1'b0, 3, 0, 32'h0},
    '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'hFFFFDEAD, 1'b0, 3, 0, 32'h0},
    '{1'b1, 2'd0, 1'b0, 32'h23, 32'h11, 32'h0, 1'b0, 4, 3, 32'h11ADBEEF},
    '{1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 32'h00000011, 1'b0, 3, 0, 32'h0}
  };

  initial begin
    logic [31:0] rd, erd, wdat, a, wd;
    logic        err, eerr, we, uns;
    logic [1:0]  sz;
    logic [11:0] wadr;
    int          cyc, ecyc, wcnt, wcyc, ewcyc, r;

    pl_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      pl_addr = 12'(i);
      pl_data = (i == 4) ? 32'h8899AABB : (32'(i) * 32'h9E3779B9);
      ref_mem[i] = pl_data;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_wren", {31'b0, mem_wren}, 32'd0);
    chk("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
    chk("rst_wr_data", mem_wr_data, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
            tbl[i].wdata, erd, eerr, ecyc, ewcyc);
      run(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
          tbl[i].wdata, rd, err, cyc, wcnt, wcyc, wdat, wadr);
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, tbl[i].err});
      chk($sformatf("v%0d_cycle", i), cyc, tbl[i].cyc);
      chk($sformatf("v%0d_wcnt", i), wcnt, (tbl[i].wcyc != 0) ? 1 : 0);
      if (tbl[i].wcyc != 0) begin
        chk($sformatf("v%0d_wcyc", i), wcyc, tbl[i].wcyc);
        chk($sformatf("v%0d_wdata", i), wdat, tbl[i].wdat);
        chk($sformatf("v%0d_waddr", i), {20'b0, wadr},
            tbl[i].addr >> 2);
      end
    end

    // reset during the WRITE of a byte store drops it silently
    req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h11; req_wdata = 32'hA5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstw_wren_before", {31'b0, mem_wren}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rstw_wren_after", {31'b0, mem_wren}, 32'd0);
    chk("rstw_ready", {31'b0, req_ready}, 32'd1);
    chk("rstw_resp", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstw_resp_later", {31'b0, resp_valid}, 32'd0);
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, erd, eerr, ecyc, ewcyc);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,
        rd, err, cyc, wcnt, wcyc, wdat, wadr);
    chk("rstw_lw_rdata", rd, erd);
    chk("rstw_lw_cycle", cyc, ecyc);

    for (int n = 0; n < 300; n++) begin
      we  = 1'($urandom % 2);
      uns = 1'($urandom % 2);
      r   = int'($urandom % 8);
      sz  = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      a   = $urandom % 256;
      if ($urandom % 4 != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom % 10 == 0)
        a = a | ((($urandom & 32'h3FFFF) + 1) << 14);
      wd = $urandom;
      model(we, sz, uns, a, wd, erd, eerr, ecyc, ewcyc);
      run(we, sz, uns, a, wd, rd, err, cyc, wcnt, wcyc, wdat, wadr);
      chk($sformatf("r%0d_rdata", n), rd, erd);
      chk($sformatf("r%0d_err", n), {31'b0, err}, {31'b0, eerr});
      chk($sformatf("r%0d_cycle", n), cyc, ecyc);
      chk($sformatf("r%0d_wcnt", n), wcnt, (ewcyc != 0) ? 1 : 0);
      if (ewcyc != 0) begin
        chk($sformatf("r%0d_wcyc", n), wcyc, ewcyc);
        chk($sformatf("r%0d_wdata", n), wdat, ref_mem[a / 4]);
        chk($sformatf("r%0d_waddr", n), {20'b0, wadr}, a >> 2);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
